// File: rtl/conv1d_pkg.sv
// Shared types and constants for the conv1d output path.
package conv1d_pkg;

  localparam int BYTE_SIZE          = 8;
  localparam int INT32_SIZE         = 32;
  localparam int MAX_INPUT_CHANNELS = 128;

  typedef logic signed [7:0] int8_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } out_word_t;

  function automatic int8_t smax8(input int8_t a, input int8_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv1d_out_fifo.sv
// Synchronous word FIFO with a registered head entry; the head is what the
// consumer sees, so it is refreshed on the pop edge or when the first word lands.
module conv1d_out_fifo
  import conv1d_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  out_word_t                  wdata,
  input  logic                       pop,
  output out_word_t                  head,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] rptr_nxt;
  logic [LW-1:0] level_q, level_d;
  out_word_t     head_q, head_d;
  out_word_t     mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == LW'(0));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign rptr_nxt = rptr_q + AW'(1);

  always_comb begin
    level_d = level_q;
    head_d  = head_q;
    wptr_d  = push_ok ? (wptr_q + AW'(1)) : wptr_q;
    rptr_d  = pop_ok ? rptr_nxt : rptr_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        level_d = level_q + LW'(1);
        if (level_q == LW'(0)) begin
          head_d = wdata;
        end else begin
          head_d = head_q;
        end
      end
      2'b01: begin
        level_d = level_q - LW'(1);
        if (level_q == LW'(1)) begin
          head_d = '0;
        end else begin
          head_d = mem_q[rptr_nxt];
        end
      end
      // With one entry the successor slot is the one being written this cycle.
      2'b11: begin
        level_d = level_q;
        if (level_q == LW'(1)) begin
          head_d = wdata;
        end else begin
          head_d = mem_q[rptr_nxt];
        end
      end
      default: begin
        level_d = level_q;
        head_d  = head_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign head  = head_q;
  assign level = level_q;

endmodule

// File: rtl/conv1d_output_packer.sv
// Packs the int8 result stream into little-endian 32-bit words and queues them.
// Optional CONV1D_POOL_MAX_EN adds a kernel-2/stride-2 max-pool across positions.
module conv1d_output_packer
  import conv1d_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int MAX_CHANNELS = 128
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [7:0]             cfg_channels,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [2:0]             out_bytes,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            positions,
  output logic                   err_len
);

  localparam int CW = $clog2(MAX_CHANNELS) + 1;

  logic [31:0]   lanes_q, lanes_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic [CW-1:0] ch_cnt_q, ch_cnt_d;
  logic [CW-1:0] ch_next;
  logic [15:0]   positions_q, positions_d;
  logic          err_q, err_d;

  logic          accept;
  logic          store_en;
  logic          push;
  int8_t         pack_byte;
  logic [31:0]   word_data;
  out_word_t     push_word;
  out_word_t     head;
  logic          full;
  logic          empty;

  assign accept  = in_valid && in_ready;
  assign ch_next = ch_cnt_q + CW'(1);

`ifdef CONV1D_POOL_MAX_EN
  logic  parity_q, parity_d;
  int8_t line_buf_q [MAX_CHANNELS];

  // Even positions only fill the line buffer; odd positions emit the pooled max.
  assign pack_byte = smax8(line_buf_q[ch_cnt_q[CW-2:0]], int8_t'(in_data));
  assign store_en  = accept && parity_q;
  assign parity_d  = (accept && in_last) ? ~parity_q : parity_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !parity_q) begin
      line_buf_q[ch_cnt_q[CW-2:0]] <= int8_t'(in_data);
    end
  end
`else
  assign pack_byte = int8_t'(in_data);
  assign store_en  = accept;
`endif

  assign word_data = lanes_q | ({24'd0, pack_byte} << {nbytes_q[1:0], 3'b000});
  assign push      = store_en && ((nbytes_q == 3'd3) || in_last);
  assign push_word = '{data: word_data, bytes: nbytes_q + 3'd1, last: in_last};

  always_comb begin
    lanes_d     = lanes_q;
    nbytes_d    = nbytes_q;
    ch_cnt_d    = ch_cnt_q;
    err_d       = err_q;
    positions_d = positions_q;
    if (push) begin
      lanes_d  = 32'd0;
      nbytes_d = 3'd0;
    end else if (store_en) begin
      lanes_d  = word_data;
      nbytes_d = nbytes_q + 3'd1;
    end else begin
      lanes_d  = lanes_q;
      nbytes_d = nbytes_q;
    end
    // A count reaching cfg without in_last flags the error and wraps silently.
    if (accept) begin
      if (in_last) begin
        ch_cnt_d = CW'(0);
        if (8'(ch_next) != cfg_channels) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else if (8'(ch_next) == cfg_channels) begin
        ch_cnt_d = CW'(0);
        err_d    = 1'b1;
      end else begin
        ch_cnt_d = ch_next;
      end
    end else begin
      ch_cnt_d = ch_cnt_q;
    end
    if (push && in_last) begin
      positions_d = positions_q + 16'd1;
    end else begin
      positions_d = positions_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      lanes_q     <= 32'd0;
      nbytes_q    <= 3'd0;
      ch_cnt_q    <= '0;
      err_q       <= 1'b0;
      positions_q <= 16'd0;
    end else begin
      lanes_q     <= lanes_d;
      nbytes_q    <= nbytes_d;
      ch_cnt_q    <= ch_cnt_d;
      err_q       <= err_d;
      positions_q <= positions_d;
    end
  end

  conv1d_out_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .wdata   (push_word),
    .pop     (out_valid && out_ready),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_bytes = head.bytes;
  assign out_last  = head.last;
  assign positions = positions_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_conv1d_output_packer.sv
// Scoreboard bench for conv1d_output_packer (DEPTH=4); define CONV1D_POOL_MAX_EN
// to run the max-pool vector instead of the direct-packing vectors.
module tb_conv1d_output_packer;
  import conv1d_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, clear;
  logic [7:0]  cfg_channels;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] positions;
  logic        err_len;

  int checks = 0;
  int errors = 0;
  out_word_t sb[$];

  always #5 clk = ~clk;

  conv1d_output_packer #(.DEPTH(DEPTH), .MAX_CHANNELS(128)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_channels(cfg_channels),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last), .level(level),
    .positions(positions), .err_len(err_len)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expw(input logic [31:0] d, input logic [2:0] n, input logic l);
    sb.push_back('{data: d, bytes: n, last: l});
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", sb.size(), 0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: compare the head word against the scoreboard whenever it is popped.
  always @(negedge clk) begin
    if (reset_n && !clear && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", out_data);
      end else begin
        out_word_t w;
        w = sb.pop_front();
        if ({out_data, out_bytes, out_last} !== w) begin
          errors++;
          $display("FAIL word actual=%h/%0d/%0d required=%h/%0d/%0d",
                   out_data, out_bytes, out_last, w.data, w.bytes, w.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; clear = 1'b0; cfg_channels = 8'd8;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_bytes", {29'd0, out_bytes}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_positions", {16'd0, positions}, 32'd0);
    chk("rst_err_len", {31'd0, err_len}, 32'd0);

`ifdef CONV1D_POOL_MAX_EN
    cfg_channels = 8'd4;
    expw(32'h7F000502, 3'd4, 1'b1);
    send(8'hFD, 1'b0); send(8'h05, 1'b0); send(8'h00, 1'b0); send(8'h7F, 1'b1);
    chk("pool_even_positions", {16'd0, positions}, 32'd0);
    chk("pool_even_level", {29'd0, level}, 32'd0);
    send(8'h02, 1'b0); send(8'hF9, 1'b0); send(8'h00, 1'b0); send(8'h80, 1'b1);
    chk("pool_positions", {16'd0, positions}, 32'd1);
    chk("pool_err_len", {31'd0, err_len}, 32'd0);
    wait_drain();
`else
    // Eight channels, two full words.
    expw(32'h04030201, 3'd4, 1'b0);
    expw(32'h08070605, 3'd4, 1'b1);
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    chk("t1_positions", {16'd0, positions}, 32'd1);
    chk("t1_err_len", {31'd0, err_len}, 32'd0);
    wait_drain();

    // Six channels, trailing partial word.
    cfg_channels = 8'd6;
    expw(32'h13121110, 3'd4, 1'b0);
    expw(32'h00001514, 3'd2, 1'b1);
    for (int i = 0; i < 6; i++) send(8'(8'h10 + i), i == 5);
    chk("t2_positions", {16'd0, positions}, 32'd2);
    chk("t2_err_len", {31'd0, err_len}, 32'd0);
    wait_drain();

    // Fill the FIFO with the consumer stalled.
    out_ready = 1'b0;
    cfg_channels = 8'd16;
    expw(32'h23222120, 3'd4, 1'b0);
    expw(32'h27262524, 3'd4, 1'b0);
    expw(32'h2B2A2928, 3'd4, 1'b0);
    expw(32'h2F2E2D2C, 3'd4, 1'b1);
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), i == 15);
    chk("t3_level_full", {29'd0, level}, 32'd4);
    chk("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_level_after_pop", {29'd0, level}, 32'd3);
    chk("t3_in_ready_after_pop", {31'd0, in_ready}, 32'd1);
    wait_drain();
    chk("t3_positions", {16'd0, positions}, 32'd3);

    // Short position flags err_len, which stays set until clear.
    cfg_channels = 8'd4;
    expw(32'h00030201, 3'd3, 1'b1);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    chk("t4_err_len", {31'd0, err_len}, 32'd1);
    expw(32'h44434241, 3'd4, 1'b1);
    send(8'h41, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0); send(8'h44, 1'b1);
    chk("t4_err_held", {31'd0, err_len}, 32'd1);
    chk("t4_positions", {16'd0, positions}, 32'd5);
    wait_drain();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("t4_err_cleared", {31'd0, err_len}, 32'd0);
    chk("t4_positions_cleared", {16'd0, positions}, 32'd0);

    // Reset mid-word drops the partial word.
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_level", {29'd0, level}, 32'd0);
    expw(32'hDDCCBBAA, 3'd4, 1'b1);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    chk("t5_positions", {16'd0, positions}, 32'd1);
    chk("t5_err_len", {31'd0, err_len}, 32'd0);
    wait_drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
